// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing generator: axis state encoding
// and the RGB888 colours used by the optional colour-bar pattern.
package video_timing_pkg;

    typedef enum logic [1:0] {
        AXIS_FRONT  = 2'd0,
        AXIS_SYNC   = 2'd1,
        AXIS_BACK   = 2'd2,
        AXIS_ACTIVE = 2'd3
    } axis_state_e;

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    // Colour of bar <idx>, left to right.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        c = RGB_BLACK;
        case (idx)
            3'd0: c = RGB_WHITE;
            3'd1: c = RGB_YELLOW;
            3'd2: c = RGB_CYAN;
            3'd3: c = RGB_GREEN;
            3'd4: c = RGB_MAGENTA;
            3'd5: c = RGB_RED;
            3'd6: c = RGB_BLUE;
            3'd7: c = RGB_BLACK;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvi_timing_gen_if.sv
// Ready/valid pixel stream into the timing generator.
// master = pixel source, slave = timing generator.
interface dvi_timing_gen_if;
    logic [23:0] rgb;
    logic        rgb_vld;
    logic        rgb_rdy;

    modport master (output rgb, output rgb_vld, input rgb_rdy);
    modport slave  (input rgb, input rgb_vld, output rgb_rdy);
endinterface

// File: rtl/video_timing_axis.sv
// One timing axis: FRONT -> SYNC -> BACK -> ACTIVE -> FRONT, each state
// counting down from (length-1). After reset or restart the axis idles in
// FRONT with count 0 and, on the first cycle restart is released, loads the
// full FRONT length so a fresh frame always starts at its first line.
module video_timing_axis
    import video_timing_pkg::*;
#(
    parameter int   FRONT_LEN  = 16,
    parameter int   SYNC_LEN   = 96,
    parameter int   BACK_LEN   = 48,
    parameter int   ACTIVE_LEN = 640,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   CNT_W      = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             restart,
    output axis_state_e      state,
    output logic             sync,
    output logic             last,
    output logic [CNT_W-1:0] coord
);

    localparam logic [CNT_W-1:0] FRONT_M1  = CNT_W'(FRONT_LEN - 1);
    localparam logic [CNT_W-1:0] SYNC_M1   = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] BACK_M1   = CNT_W'(BACK_LEN - 1);
    localparam logic [CNT_W-1:0] ACTIVE_M1 = CNT_W'(ACTIVE_LEN - 1);

    axis_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             run_q, run_d;

    // State, count and armed flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= AXIS_FRONT;
            count_q <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            run_q   <= run_d;
        end
    end

    // Next state: restart wins, then arming, then normal countdown.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        run_d   = run_q;
        if (restart) begin
            state_d = AXIS_FRONT;
            count_d = '0;
            run_d   = 1'b0;
        end else if (!run_q) begin
            state_d = AXIS_FRONT;
            count_d = FRONT_M1;
            run_d   = 1'b1;
        end else if (advance) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                case (state_q)
                    AXIS_FRONT:  begin state_d = AXIS_SYNC;   count_d = SYNC_M1;   end
                    AXIS_SYNC:   begin state_d = AXIS_BACK;   count_d = BACK_M1;   end
                    AXIS_BACK:   begin state_d = AXIS_ACTIVE; count_d = ACTIVE_M1; end
                    AXIS_ACTIVE: begin state_d = AXIS_FRONT;  count_d = FRONT_M1;  end
                    default:     begin state_d = AXIS_FRONT;  count_d = FRONT_M1;  end
                endcase
            end
        end
    end

    assign state = state_q;
    assign sync  = (state_q == AXIS_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign last  = (state_q == AXIS_ACTIVE) && (count_q == '0);
    assign coord = (state_q == AXIS_ACTIVE) ? (ACTIVE_M1 - count_q) : '0;

endmodule

// File: rtl/dvi_timing_gen.sv
// DVI video timing generator with ready/valid pixel input.
// Optional colour-bar pattern source enabled by DVI_TIMING_GEN_TESTPAT_EN
// (adds the pat_en input).
module dvi_timing_gen
    import video_timing_pkg::*;
#(
    parameter logic H_SYNC_POLARITY = 1'b0,
    parameter int   H_FRONT_PORCH   = 16,
    parameter int   H_SYNC_WIDTH    = 96,
    parameter int   H_BACK_PORCH    = 48,
    parameter int   H_ACTIVE_PIXELS = 640,
    parameter logic V_SYNC_POLARITY = 1'b0,
    parameter int   V_FRONT_PORCH   = 10,
    parameter int   V_SYNC_WIDTH    = 2,
    parameter int   V_BACK_PORCH    = 33,
    parameter int   V_ACTIVE_LINES  = 480,
    parameter int   COORD_W         = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    dvi_timing_gen_if.slave    pix,
    input  logic               underflow_clr,
`ifdef DVI_TIMING_GEN_TESTPAT_EN
    input  logic               pat_en,
`endif
    output logic               hsync,
    output logic               vsync,
    output logic               den,
    output logic [7:0]         r,
    output logic [7:0]         g,
    output logic [7:0]         b,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_start,
    output logic               underflow
);

    axis_state_e        h_state, v_state;
    logic               h_sync, v_sync, h_last, v_last_unused;
    logic [COORD_W-1:0] h_coord, v_coord;
    logic               active, pat_mode;
    logic [23:0]        pat_rgb;

    video_timing_axis #(
        .FRONT_LEN(H_FRONT_PORCH), .SYNC_LEN(H_SYNC_WIDTH), .BACK_LEN(H_BACK_PORCH),
        .ACTIVE_LEN(H_ACTIVE_PIXELS), .SYNC_POL(H_SYNC_POLARITY), .CNT_W(COORD_W)
    ) u_h_axis (
        .clk(clk), .rst(rst), .advance(en), .restart(!en),
        .state(h_state), .sync(h_sync), .last(h_last), .coord(h_coord)
    );

    video_timing_axis #(
        .FRONT_LEN(V_FRONT_PORCH), .SYNC_LEN(V_SYNC_WIDTH), .BACK_LEN(V_BACK_PORCH),
        .ACTIVE_LEN(V_ACTIVE_LINES), .SYNC_POL(V_SYNC_POLARITY), .CNT_W(COORD_W)
    ) u_v_axis (
        .clk(clk), .rst(rst), .advance(h_last), .restart(!en),
        .state(v_state), .sync(v_sync), .last(v_last_unused), .coord(v_coord)
    );

    assign active      = en && (h_state == AXIS_ACTIVE) && (v_state == AXIS_ACTIVE);
    assign pix.rgb_rdy = active && !pat_mode;

`ifdef DVI_TIMING_GEN_TESTPAT_EN
    localparam int                 BAR_W  = H_ACTIVE_PIXELS >> 3;
    localparam logic [COORD_W-1:0] BAR_M1 = COORD_W'(BAR_W - 1);

    logic               pat_mode_q, pat_mode_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    logic [COORD_W-1:0] bar_cnt_q, bar_cnt_d;

    // Pattern mode latch and colour-bar position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_mode_q <= 1'b0;
            bar_idx_q  <= '0;
            bar_cnt_q  <= '0;
        end else begin
            pat_mode_q <= pat_mode_d;
            bar_idx_q  <= bar_idx_d;
            bar_cnt_q  <= bar_cnt_d;
        end
    end

    // pat_en only taken outside the vertical active region so a frame never
    // mixes sources; the last bar (black) simply runs to the end of line.
    always_comb begin
        pat_mode_d = pat_mode_q;
        bar_idx_d  = bar_idx_q;
        bar_cnt_d  = bar_cnt_q;
        if (v_state != AXIS_ACTIVE) pat_mode_d = pat_en;
        if (!active) begin
            bar_idx_d = '0;
            bar_cnt_d = BAR_M1;
        end else if (bar_cnt_q != '0) begin
            bar_cnt_d = bar_cnt_q - COORD_W'(1);
        end else if (bar_idx_q != 3'd7) begin
            bar_idx_d = bar_idx_q + 3'd1;
            bar_cnt_d = BAR_M1;
        end
    end

    assign pat_mode = pat_mode_q;
    assign pat_rgb  = bar_colour(bar_idx_q);
`else
    assign pat_mode = 1'b0;
    assign pat_rgb  = RGB_BLACK;
`endif

    logic               hsync_q, hsync_d, vsync_q, vsync_d, den_q, den_d;
    logic [23:0]        rgb_q, rgb_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               frame_start_q, frame_start_d, underflow_q, underflow_d;

    // Output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q       <= ~H_SYNC_POLARITY;
            vsync_q       <= ~V_SYNC_POLARITY;
            den_q         <= 1'b0;
            rgb_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            den_q         <= den_d;
            rgb_q         <= rgb_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    // Blanking by default; en low blanks immediately, before the axes rewind.
    always_comb begin
        hsync_d       = ~H_SYNC_POLARITY;
        vsync_d       = ~V_SYNC_POLARITY;
        den_d         = 1'b0;
        rgb_d         = '0;
        x_d           = '0;
        y_d           = '0;
        frame_start_d = 1'b0;
        underflow_d   = underflow_q;
        if (en) begin
            hsync_d = h_sync;
            vsync_d = v_sync;
        end
        if (active) begin
            den_d         = 1'b1;
            x_d           = h_coord;
            y_d           = v_coord;
            frame_start_d = (h_coord == '0) && (v_coord == '0);
            if (pat_mode)         rgb_d = pat_rgb;
            else if (pix.rgb_vld) rgb_d = pix.rgb;
        end
        if (underflow_clr) underflow_d = 1'b0;
        if (pix.rgb_rdy && !pix.rgb_vld) underflow_d = 1'b1;
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign den         = den_q;
    assign r           = rgb_q[23:16];
    assign g           = rgb_q[15:8];
    assign b           = rgb_q[7:0];
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Directed testbench for dvi_timing_gen in a small mode:
// H 2/3/4/8 (17 cycles/line), V 1/1/2/4 (136 cycles/frame), polarities 0.
// Edge k counts rising edges from the first edge that samples en=1 (k=1).
// Before edge k the source presents rgb = 0x100000 + k, so an output pixel
// seen after edge k carries that value. Output state after edge k reflects
// axis position p=(k-2)%17, line L=((k-2)/17)%8.
module tb_dvi_timing_gen;

    logic       clk = 1'b0;
    logic       rst, en, underflow_clr;
    logic       hsync, vsync, den, frame_start, underflow;
    logic [7:0] r, g, b, x, y;
    int         checks = 0;
    int         errors = 0;
    int         k = 0;
    int         fs_count = 0;

    dvi_timing_gen_if ifc();

    always #5 clk = ~clk;

    dvi_timing_gen #(
        .H_SYNC_POLARITY(1'b0), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3),
        .H_BACK_PORCH(4), .H_ACTIVE_PIXELS(8),
        .V_SYNC_POLARITY(1'b0), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1),
        .V_BACK_PORCH(2), .V_ACTIVE_LINES(4), .COORD_W(8)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pix(ifc), .underflow_clr(underflow_clr),
`ifdef DVI_TIMING_GEN_TESTPAT_EN
        .pat_en(1'b0),
`endif
        .hsync(hsync), .vsync(vsync), .den(den), .r(r), .g(g), .b(b),
        .x(x), .y(y), .frame_start(frame_start), .underflow(underflow)
    );

`ifdef DVI_TIMING_GEN_TESTPAT_EN
    logic        en_p, hsync_p, vsync_p, den_p, fs_p, uf_p, rdy_seen;
    logic [7:0]  r_p, g_p, b_p;
    logic [11:0] x_p, y_p;
    dvi_timing_gen_if ifc_p();

    dvi_timing_gen u_pat (
        .clk(clk), .rst(rst), .en(en_p), .pix(ifc_p), .underflow_clr(1'b0),
        .pat_en(1'b1),
        .hsync(hsync_p), .vsync(vsync_p), .den(den_p), .r(r_p), .g(g_p), .b(b_p),
        .x(x_p), .y(y_p), .frame_start(fs_p), .underflow(uf_p)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_hsync"}, 32'(hsync), 32'd1);
        check({tag, "_vsync"}, 32'(vsync), 32'd1);
        check({tag, "_den"}, 32'(den), 32'd0);
        check({tag, "_rgb"}, 32'({r, g, b}), 32'd0);
        check({tag, "_xy"}, 32'({x, y}), 32'd0);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
        check({tag, "_uf"}, 32'(underflow), 32'd0);
        check({tag, "_rdy"}, 32'(ifc.rgb_rdy), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
        ifc.rgb = 24'h100000 + 24'(k + 1);
        if (frame_start) fs_count++;
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; underflow_clr = 1'b0;
        ifc.rgb = 24'h100001; ifc.rgb_vld = 1'b1;
`ifdef DVI_TIMING_GEN_TESTPAT_EN
        en_p = 1'b0; rdy_seen = 1'b0;
        ifc_p.rgb = 24'h123456; ifc_p.rgb_vld = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        en = 1'b1;

        // Sync timing from the first enabled edge.
        step();
        check("k1_hsync", 32'(hsync), 32'd1);
        check("k1_den", 32'(den), 32'd0);
        run_to(3);  check("k3_hsync", 32'(hsync), 32'd1);
        run_to(4);  check("k4_hsync", 32'(hsync), 32'd0);
        run_to(6);  check("k6_hsync", 32'(hsync), 32'd0);
        run_to(7);  check("k7_hsync", 32'(hsync), 32'd1);
        run_to(18); check("k18_vsync", 32'(vsync), 32'd1);
        run_to(19); check("k19_vsync", 32'(vsync), 32'd0);
        run_to(35); check("k35_vsync", 32'(vsync), 32'd0);
        run_to(36); check("k36_vsync", 32'(vsync), 32'd1);

        // First active pixel: rgb_rdy 77 edges after the first enabled edge.
        run_to(77); check("k77_rdy", 32'(ifc.rgb_rdy), 32'd0);
        run_to(78); check("k78_rdy", 32'(ifc.rgb_rdy), 32'd1);
        check("k78_den", 32'(den), 32'd0);
        run_to(79);
        check("k79_den", 32'(den), 32'd1);
        check("k79_fs", 32'(frame_start), 32'd1);
        check("k79_xy", 32'({x, y}), 32'h0000);
        check("k79_rgb", 32'({r, g, b}), 32'h10004F);
        run_to(80);
        check("k80_fs", 32'(frame_start), 32'd0);
        check("k80_x", 32'(x), 32'd1);
        check("k80_rgb", 32'({r, g, b}), 32'h100050);
        run_to(86);
        check("k86_den", 32'(den), 32'd1);
        check("k86_x", 32'(x), 32'd7);
        run_to(87);
        check("k87_den", 32'(den), 32'd0);
        check("k87_rgb", 32'({r, g, b}), 32'd0);
        check("k87_x", 32'(x), 32'd0);

        // Underflow at x=3, y=1, then clear coinciding with a new underflow.
        run_to(98);
        check("k98_uf", 32'(underflow), 32'd0);
        ifc.rgb_vld = 1'b0;
        step();
        check("k99_xy", 32'({x, y}), 32'h0301);
        check("k99_den", 32'(den), 32'd1);
        check("k99_rgb", 32'({r, g, b}), 32'd0);
        check("k99_uf", 32'(underflow), 32'd1);
        ifc.rgb_vld = 1'b1;
        step();
        check("k100_rgb", 32'({r, g, b}), 32'h100064);
        check("k100_uf", 32'(underflow), 32'd1);
        ifc.rgb_vld = 1'b0; underflow_clr = 1'b1;
        step();
        check("k101_x", 32'(x), 32'd5);
        check("k101_rgb", 32'({r, g, b}), 32'd0);
        check("k101_uf_set_wins", 32'(underflow), 32'd1);
        ifc.rgb_vld = 1'b1;
        step();
        check("k102_uf_cleared", 32'(underflow), 32'd0);
        check("k102_rgb", 32'({r, g, b}), 32'h100066);
        underflow_clr = 1'b0;

        // Frame period 136.
        run_to(214); check("k214_fs", 32'(frame_start), 32'd0);
        run_to(215);
        check("k215_fs", 32'(frame_start), 32'd1);
        check("k215_xy", 32'({x, y}), 32'h0000);
        check("k215_den", 32'(den), 32'd1);
        run_to(216); check("k216_fs", 32'(frame_start), 32'd0);

        // Drop en mid active line, then restart a full frame.
        run_to(220);
        check("k220_den", 32'(den), 32'd1);
        check("k220_x", 32'(x), 32'd5);
        en = 1'b0;
        step();
        check("k221_den", 32'(den), 32'd0);
        check("k221_rgb", 32'({r, g, b}), 32'd0);
        check("k221_x", 32'(x), 32'd0);
        check("k221_rdy", 32'(ifc.rgb_rdy), 32'd0);
        run_to(224);
        check("k224_hsync", 32'(hsync), 32'd1);
        en = 1'b1;
        run_to(227); check("k227_hsync", 32'(hsync), 32'd1);
        run_to(228); check("k228_hsync", 32'(hsync), 32'd0);
        run_to(243); check("k243_vsync", 32'(vsync), 32'd0);
        run_to(300); check("fs_count", 32'(fs_count), 32'd2);
        run_to(301); check("k301_rdy", 32'(ifc.rgb_rdy), 32'd0);
        run_to(302);
        check("k302_rdy", 32'(ifc.rgb_rdy), 32'd1);
        check("k302_fs", 32'(frame_start), 32'd0);
        run_to(303);
        check("k303_fs", 32'(frame_start), 32'd1);
        check("k303_xy", 32'({x, y}), 32'h0000);
        check("k303_rgb", 32'({r, g, b}), 32'h10012F);

        // Asynchronous reset while den=1 with underflow set.
        ifc.rgb_vld = 1'b0;
        step();
        check("k304_den", 32'(den), 32'd1);
        check("k304_uf", 32'(underflow), 32'd1);
        ifc.rgb_vld = 1'b1;
        rst = 1'b1;
        #2;
        check_reset("async_rst");
        step();
        rst = 1'b0;

`ifdef DVI_TIMING_GEN_TESTPAT_EN
        // Colour bars at default 640x480 timing.
        en_p = 1'b1;
        for (int i = 0; i < 40000 && !den_p; i++) begin
            @(posedge clk);
            #1;
            if (ifc_p.rgb_rdy) rdy_seen = 1'b1;
        end
        check("pat_den_timeout", 32'(den_p), 32'd1);
        check("pat_x0", 32'(x_p), 32'd0);
        check("pat_x0_rgb", 32'({r_p, g_p, b_p}), 32'hFFFFFF);
        repeat (80) begin
            @(posedge clk);
            #1;
            if (ifc_p.rgb_rdy) rdy_seen = 1'b1;
        end
        check("pat_x80", 32'(x_p), 32'd80);
        check("pat_x80_rgb", 32'({r_p, g_p, b_p}), 32'hFFFF00);
        repeat (559) begin
            @(posedge clk);
            #1;
            if (ifc_p.rgb_rdy) rdy_seen = 1'b1;
        end
        check("pat_x639", 32'(x_p), 32'd639);
        check("pat_x639_rgb", 32'({r_p, g_p, b_p}), 32'h000000);
        check("pat_rdy_never", 32'(rdy_seen), 32'd0);
        check("pat_uf", 32'(uf_p), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
